// File: rtl/friscv_icache_pkg.sv
// ============================================================================
// Module  : friscv_icache_pkg
// Purpose : Shared types and address-split helpers for the N-way icache
//           storage (state encoding, field-width functions, entry layout).
// Macros  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package friscv_icache_pkg;

    // Storage controller state: explicit 1-bit encoding
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } icache_state_t;

    // Byte-in-word offset width
    function automatic int f_byte_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // Word-in-line offset width
    function automatic int f_woff_w(input int line_w, input int xlen);
        return $clog2(line_w / xlen);
    endfunction

    // Set index width
    function automatic int f_index_w(input int depth);
        return $clog2(depth);
    endfunction

    // Tag width: whatever is left of the byte address
    function automatic int f_tag_w(input int addr_w, input int xlen,
                                   input int line_w, input int depth);
        return addr_w - f_byte_w(xlen) - f_woff_w(line_w, xlen) - f_index_w(depth);
    endfunction

    // Logical entry of one way for the default geometry (32-bit address,
    // 128-bit line, 512 sets). The valid bit lives in the top-level flop
    // array, tag and line live in the per-way RAM.
    localparam int C_DEF_TAG_W  = 19;
    localparam int C_DEF_LINE_W = 128;

    typedef struct packed {
        logic                    valid;
        logic [C_DEF_TAG_W-1:0]  tag;
        logic [C_DEF_LINE_W-1:0] line;
    } icache_entry_t;

endpackage

`default_nettype wire

// File: rtl/friscv_icache_ways_if.sv
// ============================================================================
// Module  : friscv_icache_ways_if
// Purpose : Fetch/refill bus between the icache controller (master) and the
//           N-way storage (slave).
// Macros  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface friscv_icache_ways_if #(
    parameter int ADDR_W       = 32,
    parameter int XLEN         = 32,
    parameter int CACHE_LINE_W = 128
);
    logic                    flush;
    logic                    ready;
    logic                    wen;
    logic [ADDR_W-1:0]       waddr;
    logic [CACHE_LINE_W-1:0] wdata;
    logic                    ren;
    logic [ADDR_W-1:0]       raddr;
    logic                    rvalid;
    logic [XLEN-1:0]         rdata;
    logic                    hit;
    logic                    miss;
    logic [31:0]             hit_cnt;
    logic [31:0]             miss_cnt;

    modport master (
        output flush, wen, waddr, wdata, ren, raddr,
        input  ready, rvalid, rdata, hit, miss, hit_cnt, miss_cnt
    );

    modport slave (
        input  flush, wen, waddr, wdata, ren, raddr,
        output ready, rvalid, rdata, hit, miss, hit_cnt, miss_cnt
    );
endinterface

`default_nettype wire

// File: rtl/friscv_icache_way.sv
// ============================================================================
// Module  : friscv_icache_way
// Purpose : One way of the icache: tag + line arrays, write port, registered
//           read port, and an asynchronous tag peek at the write set used by
//           the refill way selection.
// Macros  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module friscv_icache_way #(
    parameter int TAG_W   = 19,
    parameter int INDEX_W = 9,
    parameter int LINE_W  = 128
) (
    input  wire logic               aclk,
    input  wire logic               i_wen,
    input  wire logic [INDEX_W-1:0] i_windex,
    input  wire logic [TAG_W-1:0]   i_wtag,
    input  wire logic [LINE_W-1:0]  i_wdata,
    output logic      [TAG_W-1:0]   o_wset_tag,
    input  wire logic               i_ren,
    input  wire logic [INDEX_W-1:0] i_rindex,
    output logic      [TAG_W-1:0]   o_rtag,
    output logic      [LINE_W-1:0]  o_rline
);

    localparam int C_DEPTH = 2 ** INDEX_W;

    logic [TAG_W-1:0]  r_tag_mem  [C_DEPTH];
    logic [LINE_W-1:0] r_data_mem [C_DEPTH];
    logic [TAG_W-1:0]  r_rtag;
    logic [LINE_W-1:0] r_rline;

    // RAM write and registered read; a same-cycle read sees the old entry
    always_ff @(posedge aclk) begin
        if (i_wen) begin
            r_tag_mem[i_windex]  <= i_wtag;
            r_data_mem[i_windex] <= i_wdata;
        end
        if (i_ren) begin
            r_rtag  <= r_tag_mem[i_rindex];
            r_rline <= r_data_mem[i_rindex];
        end
    end

    assign o_wset_tag = r_tag_mem[i_windex];
    assign o_rtag     = r_rtag;
    assign o_rline    = r_rline;

endmodule

`default_nettype wire

// File: rtl/friscv_icache_ways.sv
// ============================================================================
// Module  : friscv_icache_ways
// Purpose : N-way set-associative instruction cache storage. Holds valid
//           bits, per-set round-robin pointers, the flush walk FSM, refill
//           way selection, lookup hit mux and optional hit/miss counters.
// Macros  : FRISCV_ICACHE_STATS_EN - enables saturating hit/miss counters
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module friscv_icache_ways
    import friscv_icache_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 32,
    parameter int CACHE_LINE_W = 128,
    parameter int CACHE_DEPTH  = 512,
    parameter int NB_WAYS      = 2
) (
    input  wire logic           aclk,
    input  wire logic           srst,
    friscv_icache_ways_if.slave bus
);

    localparam int BYTE_W  = f_byte_w(XLEN);
    localparam int WOFF_W  = f_woff_w(CACHE_LINE_W, XLEN);
    localparam int INDEX_W = f_index_w(CACHE_DEPTH);
    localparam int TAG_W   = f_tag_w(ADDR_W, XLEN, CACHE_LINE_W, CACHE_DEPTH);
    localparam int RR_W    = (NB_WAYS > 1) ? $clog2(NB_WAYS) : 1;
    localparam logic [INDEX_W-1:0] C_LAST_IDX = INDEX_W'(CACHE_DEPTH - 1);

    // ---------------- FSM ----------------
    icache_state_t      r_state;
    icache_state_t      w_state_nxt;
    logic [INDEX_W-1:0] r_walk_idx;
    logic [INDEX_W-1:0] w_walk_nxt;
    logic               w_ready;
    logic               w_clear;

    // State register and walk index
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state    <= FLUSH;
            r_walk_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_walk_idx <= w_walk_nxt;
        end
    end

    // Next state: a flush pulse always (re)starts the walk at set 0
    always_comb begin
        w_state_nxt = r_state;
        w_walk_nxt  = r_walk_idx;
        case (r_state)
            IDLE: begin
                if (bus.flush) begin
                    w_state_nxt = FLUSH;
                    w_walk_nxt  = '0;
                end
            end
            FLUSH: begin
                if (bus.flush) begin
                    w_walk_nxt = '0;
                end else if (r_walk_idx == C_LAST_IDX) begin
                    w_state_nxt = IDLE;
                    w_walk_nxt  = '0;
                end else begin
                    w_walk_nxt = r_walk_idx + INDEX_W'(1);
                end
            end
            default: begin
                w_state_nxt = FLUSH;
                w_walk_nxt  = '0;
            end
        endcase
    end

    // FSM outputs: accept traffic only when idle, clear one set per walk cycle
    always_comb begin
        w_ready = (r_state == IDLE) && !srst;
        w_clear = (r_state == FLUSH);
    end

    // ---------------- request decode ----------------
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic [INDEX_W-1:0] w_rindex;
    logic [TAG_W-1:0]   w_rtag;
    logic [WOFF_W-1:0]  w_rwoff;
    logic [INDEX_W-1:0] w_windex;
    logic [TAG_W-1:0]   w_wtag;

    // A flush pulse in the same cycle drops any request
    assign w_rd_acc = w_ready && !bus.flush && bus.ren;
    assign w_wr_acc = w_ready && !bus.flush && bus.wen;

    assign w_rindex = bus.raddr[BYTE_W+WOFF_W +: INDEX_W];
    assign w_rtag   = bus.raddr[ADDR_W-1 -: TAG_W];
    assign w_rwoff  = bus.raddr[BYTE_W +: WOFF_W];
    assign w_windex = bus.waddr[BYTE_W+WOFF_W +: INDEX_W];
    assign w_wtag   = bus.waddr[ADDR_W-1 -: TAG_W];

    // ---------------- ways ----------------
    logic [NB_WAYS-1:0]      w_wsel;
    logic [TAG_W-1:0]        w_way_wtag  [NB_WAYS];
    logic [TAG_W-1:0]        w_way_rtag  [NB_WAYS];
    logic [CACHE_LINE_W-1:0] w_way_rline [NB_WAYS];

    for (genvar g = 0; g < NB_WAYS; g++) begin : g_way
        friscv_icache_way #(
            .TAG_W   (TAG_W),
            .INDEX_W (INDEX_W),
            .LINE_W  (CACHE_LINE_W)
        ) u_way (
            .aclk       (aclk),
            .i_wen      (w_wr_acc && w_wsel[g]),
            .i_windex   (w_windex),
            .i_wtag     (w_wtag),
            .i_wdata    (bus.wdata),
            .o_wset_tag (w_way_wtag[g]),
            .i_ren      (w_rd_acc),
            .i_rindex   (w_rindex),
            .o_rtag     (w_way_rtag[g]),
            .o_rline    (w_way_rline[g])
        );
    end

    // ---------------- valid bits and refill way selection ----------------
    logic [NB_WAYS-1:0] r_valid [CACHE_DEPTH];
    logic [NB_WAYS-1:0] w_wvalid;
    logic [NB_WAYS-1:0] w_wmatch;
    logic               w_evict;
    logic [RR_W-1:0]    w_rr_cur;

    assign w_wvalid = r_valid[w_windex];

    // Way choice: same-tag way, else lowest invalid, else round-robin victim
    always_comb begin : p_way_sel
        logic v_found;
        w_wmatch = '0;
        w_wsel   = '0;
        v_found  = 1'b0;
        for (int w = 0; w < NB_WAYS; w++) begin
            w_wmatch[w] = w_wvalid[w] && (w_way_wtag[w] == w_wtag);
        end
        for (int w = 0; w < NB_WAYS; w++) begin
            if (!v_found && w_wmatch[w]) begin
                w_wsel[w] = 1'b1;
                v_found   = 1'b1;
            end
        end
        for (int w = 0; w < NB_WAYS; w++) begin
            if (!v_found && !w_wvalid[w]) begin
                w_wsel[w] = 1'b1;
                v_found   = 1'b1;
            end
        end
        w_evict = !v_found;
        if (!v_found) begin
            w_wsel = NB_WAYS'(1) << w_rr_cur;
        end
    end

    // Valid array: cleared set by set during the walk, set on refill
    always_ff @(posedge aclk) begin
        if (w_clear) begin
            r_valid[r_walk_idx] <= '0;
        end else if (w_wr_acc) begin
            r_valid[w_windex] <= w_wvalid | w_wsel;
        end
    end

    if (NB_WAYS > 1) begin : g_rr
        logic [RR_W-1:0] r_rr [CACHE_DEPTH];

        // Round-robin pointer advances only when it picked the victim
        always_ff @(posedge aclk) begin
            if (w_clear) begin
                r_rr[r_walk_idx] <= '0;
            end else if (w_wr_acc && w_evict) begin
                r_rr[w_windex] <= r_rr[w_windex] + RR_W'(1);
            end
        end

        assign w_rr_cur = r_rr[w_windex];
    end else begin : g_no_rr
        assign w_rr_cur = '0;
    end

    // ---------------- lookup pipeline ----------------
    logic                    r_rvalid;
    logic [NB_WAYS-1:0]      r_rset_valid;
    logic [TAG_W-1:0]        r_rtag;
    logic [WOFF_W-1:0]       r_rwoff;
    logic [NB_WAYS-1:0]      w_rmatch;
    logic [CACHE_LINE_W-1:0] w_line_sel;
    logic                    w_one_match;
    logic                    w_hit;
    logic                    w_miss;

    // Result-valid flag
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_acc;
        end
    end

    // Lookup context captured alongside the RAM read (pre-write valid bits)
    always_ff @(posedge aclk) begin
        if (w_rd_acc) begin
            r_rset_valid <= r_valid[w_rindex];
            r_rtag       <= w_rtag;
            r_rwoff      <= w_rwoff;
        end
    end

    // Tag compare and line mux; a hit requires exactly one matching way
    always_comb begin
        w_rmatch   = '0;
        w_line_sel = '0;
        for (int w = 0; w < NB_WAYS; w++) begin
            w_rmatch[w] = r_rset_valid[w] && (w_way_rtag[w] == r_rtag);
            if (w_rmatch[w]) begin
                w_line_sel = w_line_sel | w_way_rline[w];
            end
        end
        w_one_match = (w_rmatch != '0) && ((w_rmatch & (w_rmatch - NB_WAYS'(1))) == '0);
        w_hit       = r_rvalid && w_one_match;
        w_miss      = r_rvalid && !w_one_match;
    end

    assign bus.ready  = w_ready;
    assign bus.rvalid = r_rvalid;
    assign bus.hit    = w_hit;
    assign bus.miss   = w_miss;
    assign bus.rdata  = w_hit ? w_line_sel[r_rwoff*XLEN +: XLEN] : '0;

    // ---------------- statistics ----------------
`ifdef FRISCV_ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Saturating hit/miss counters, cleared only by reset
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;
`else
    assign bus.hit_cnt  = '0;
    assign bus.miss_cnt = '0;
`endif

endmodule

`default_nettype wire
